sb_output_queue: RTL and testbench
==================================

Name: sb_output_queue

Overview:
- Per-output-port address queueing and read scheduling stage, directly downstream of the shared packet buffer.
- Takes each buffer address returned by the shared buffer write path and enqueues it on the queue for its destination port.
- Arbitrates round-robin among ports that are non-empty and ready, and issues one shared-buffer read (rd_req + ip) per cycle.
- Steers the returned word to the granted port. Issuing ip with rd_req also returns that address to the buffer's free pool.

Parameters:
- ADDR_BITWIDTH, 4: shared buffer address width; matches the buffer's address width.
- DATA_BITWIDTH, 4: packet data word width; matches the buffer's data width.
- PORT_SEL_BITWIDTH, 2: port index width; NUM_PORTS = 2**PORT_SEL_BITWIDTH.
- QUEUE_DEPTH_BITWIDTH, 3: per-port queue depth = 2**QUEUE_DEPTH_BITWIDTH addresses.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- enq_valid, in, 1: enq_addr/enq_port valid this cycle.
- enq_port, in, PORT_SEL_BITWIDTH: destination port of the enqueued address.
- enq_addr, in, ADDR_BITWIDTH: buffer address (the buffer's op output).
- enq_ready, out, 1: combinational; high when the queue selected by enq_port is not full.
- port_ready, in, NUM_PORTS: per-port sink can accept a word two cycles later.
- sb_rd_req, out, 1: registered read request to the shared buffer.
- sb_ip, out, ADDR_BITWIDTH: registered read address to the shared buffer.
- sb_odata, in, DATA_BITWIDTH: buffer read data, valid one cycle after sb_rd_req.
- out_valid, out, NUM_PORTS: one-hot; the indicated port receives out_data this cycle.
- out_data, out, DATA_BITWIDTH: equals sb_odata (combinational pass-through).

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - All queue read/write pointers and counts go to 0; rr pointer goes to 0.
  - sb_rd_req=0, sb_ip=0, out_valid=0.
  - Reset mid-operation discards all queued addresses and any in-flight read. out_valid is 0 in the cycle after the reset edge, even if sb_odata is valid.
- Queues:
  - NUM_PORTS independent circular FIFOs, each 2**QUEUE_DEPTH_BITWIDTH entries.
  - Counts are QUEUE_DEPTH_BITWIDTH+1 bits wide; pointers wrap modulo depth.
  - full = (count == depth); empty = (count == 0).
- Enqueue:
  - On an edge with enq_valid=1 and the target queue not full, write enq_addr at the write pointer, then increment the write pointer and count.
  - enq_valid=1 with the target queue full: the address is dropped and queue state is unchanged.
- Grant (combinational, cycle T-1):
  - Eligible port = count != 0 and port_ready[p]=1, using registered counts.
  - Search order starts at rr and proceeds rr, rr+1, … modulo NUM_PORTS; the first eligible port wins.
  - No eligible port: no grant.
- Issue (edge ending T-1):
  - If granted port g: sb_rd_req<=1, sb_ip<=head of queue g; queue g read pointer increments, count decrements; rr<=g+1 (wraps).
  - If no grant: sb_rd_req<=0, sb_ip holds its value, rr is unchanged.
- Return (cycle T+1):
  - A registered one-hot of g, delayed one cycle after sb_rd_req, drives out_valid in cycle T+1.
  - out_data = sb_odata in that cycle.
- Latency and throughput:
  - Grant decision to out_valid is 2 edges.
  - One read issued and one word delivered per cycle sustained; there is no bubble between back-to-back grants.
- Simultaneous enqueue and dequeue on the same queue: both take effect and the count is unchanged. This is legal even when the queue is full (the dequeue frees a slot in the same edge, but enq_ready still reports full, so upstream must not rely on it).
- Enqueue into an empty queue: the entry becomes eligible the cycle after the write.
- port_ready: sampled only at grant. A granted port must accept its beat; there is no back-pressure after grant.

Optional Feature:
- Macro: SB_OQ_DROP_CNT_EN.
- Defined:
  - Adds output drop_count (16 bits).
  - Increments on every enqueue attempt to a full queue; saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: no port and no counter logic; drops are silent.

Test Plan:
- Reset then idle: enq_valid=0, port_ready=4'hF for 10 cycles -> sb_rd_req=0, out_valid=0, sb_ip=0 throughout.
- Single packet word:
  - Stimulus: enqueue addr 4'h5 to port 2; sb_odata=4'hA returned one cycle after sb_rd_req.
  - Response: sb_rd_req=1 and sb_ip=5 one cycle after grant; out_valid=4'b0100 with out_data=4'hA on the next cycle.
- Round-robin:
  - Stimulus: enqueue addrs 1,2,3,4 to ports 0,1,2,3; all ports ready.
  - Response: sb_ip issued 1,2,3,4 on consecutive cycles; out_valid walks 0001,0010,0100,1000.
- Full and drop:
  - Stimulus: with port_ready[0]=0, enqueue 9 addrs to port 0 (depth 8).
  - Response: enq_ready=0 once 8 are queued; the 9th is dropped; drop_count=1 with SB_OQ_DROP_CNT_EN.
  - Then set port_ready[0]=1: exactly 8 reads are issued, in FIFO order.
- Not-ready skip: ports 0 and 1 non-empty, port_ready=4'b0010 -> only port 1 is granted. Port 0 is granted the cycle after port_ready[0] rises.
- Reset mid-flight: assert rst in the cycle sb_rd_req=1 -> out_valid=0 next cycle; all queues empty afterwards (no grant with all ports ready).

Source files
------------

// File: rtl/sb_output_queue.sv
`default_nettype none
// ============================================================================
// Module   : sb_output_queue
// Purpose  : Per-output-port address queues with round-robin read scheduling
//            in front of the shared packet buffer. Define SB_OQ_DROP_CNT_EN
//            to add a saturating drop_count output.
// Revision : 1.0 - initial release
// ============================================================================
module sb_output_queue #(
    parameter int ADDR_BITWIDTH        = 4,
    parameter int DATA_BITWIDTH        = 4,
    parameter int PORT_SEL_BITWIDTH    = 2,
    parameter int QUEUE_DEPTH_BITWIDTH = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enq_valid,
    input  logic [PORT_SEL_BITWIDTH-1:0]        enq_port,
    input  logic [ADDR_BITWIDTH-1:0]            enq_addr,
    output logic                                enq_ready,
    input  logic [(2**PORT_SEL_BITWIDTH)-1:0]   port_ready,
    output logic                                sb_rd_req,
    output logic [ADDR_BITWIDTH-1:0]            sb_ip,
    input  logic [DATA_BITWIDTH-1:0]            sb_odata,
    output logic [(2**PORT_SEL_BITWIDTH)-1:0]   out_valid,
    output logic [DATA_BITWIDTH-1:0]            out_data
`ifdef SB_OQ_DROP_CNT_EN
    ,
    output logic [15:0]                         drop_count
`endif
);

    localparam int c_NUM_PORTS = 2**PORT_SEL_BITWIDTH;
    localparam int c_DEPTH     = 2**QUEUE_DEPTH_BITWIDTH;
    localparam logic [QUEUE_DEPTH_BITWIDTH:0] c_FULL_COUNT =
        {1'b1, {QUEUE_DEPTH_BITWIDTH{1'b0}}};

    logic [c_NUM_PORTS-1:0]                     w_full;
    logic [c_NUM_PORTS-1:0]                     w_elig;
    logic [c_NUM_PORTS-1:0][ADDR_BITWIDTH-1:0]  w_head;
    logic                                       w_grant_vld;
    logic [PORT_SEL_BITWIDTH-1:0]               w_grant_idx;
    logic [c_NUM_PORTS-1:0]                     w_grant_oh;

    logic [PORT_SEL_BITWIDTH-1:0]               r_rr;
    logic                                       r_sb_rd_req;
    logic [ADDR_BITWIDTH-1:0]                   r_sb_ip;
    logic [c_NUM_PORTS-1:0]                     r_issue_oh;
    logic [c_NUM_PORTS-1:0]                     r_out_valid;

    // ------------------------------------------------------------------
    // Per-port circular FIFOs of buffer addresses
    // ------------------------------------------------------------------
    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_port
        logic [ADDR_BITWIDTH-1:0]          r_mem [c_DEPTH];
        logic [QUEUE_DEPTH_BITWIDTH-1:0]   r_wptr;
        logic [QUEUE_DEPTH_BITWIDTH-1:0]   r_rptr;
        logic [QUEUE_DEPTH_BITWIDTH:0]     r_count;
        logic                              w_deq;
        logic                              w_enq;

        assign w_full[p] = (r_count == c_FULL_COUNT);
        assign w_elig[p] = (r_count != '0) && port_ready[p];
        assign w_head[p] = r_mem[r_rptr];
        assign w_deq     = w_grant_vld && (w_grant_idx == PORT_SEL_BITWIDTH'(p));
        // A dequeue in the same edge frees the slot, so a full queue still accepts.
        assign w_enq     = enq_valid && (enq_port == PORT_SEL_BITWIDTH'(p)) &&
                           (!w_full[p] || w_deq);

        always_ff @(posedge clk) begin
            if (w_enq) begin
                r_mem[r_wptr] <= enq_addr;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_deq) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign enq_ready = !w_full[enq_port];

    // ------------------------------------------------------------------
    // Round-robin grant starting at r_rr; lowest offset from r_rr wins
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = c_NUM_PORTS - 1; i >= 0; i--) begin
            if (w_elig[r_rr + PORT_SEL_BITWIDTH'(i)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = r_rr + PORT_SEL_BITWIDTH'(i);
            end
        end
    end

    always_comb begin
        w_grant_oh              = '0;
        w_grant_oh[w_grant_idx] = w_grant_vld;
    end

    // ------------------------------------------------------------------
    // Read issue and return steering
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr        <= '0;
            r_sb_rd_req <= 1'b0;
            r_sb_ip     <= '0;
            r_issue_oh  <= '0;
            r_out_valid <= '0;
        end else begin
            r_sb_rd_req <= w_grant_vld;
            r_issue_oh  <= w_grant_oh;
            r_out_valid <= r_issue_oh;
            if (w_grant_vld) begin
                r_sb_ip <= w_head[w_grant_idx];
                r_rr    <= w_grant_idx + 1'b1;
            end
        end
    end

    assign sb_rd_req = r_sb_rd_req;
    assign sb_ip     = r_sb_ip;
    assign out_valid = r_out_valid;
    assign out_data  = sb_odata;

`ifdef SB_OQ_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_count;

    assign w_drop = enq_valid && w_full[enq_port] &&
                    !(w_grant_vld && (w_grant_idx == enq_port));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sb_output_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_output_queue
// Purpose  : Directed plus random bench for sb_output_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_output_queue;

    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int PW    = 2;
    localparam int QW    = 3;
    localparam int NP    = 4;
    localparam int DEPTH = 8;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            enq_valid  = 1'b0;
    logic [PW-1:0]   enq_port   = '0;
    logic [AW-1:0]   enq_addr   = '0;
    logic            enq_ready;
    logic [NP-1:0]   port_ready = '0;
    logic            sb_rd_req;
    logic [AW-1:0]   sb_ip;
    logic [DW-1:0]   sb_odata   = '0;
    logic [NP-1:0]   out_valid;
    logic [DW-1:0]   out_data;
`ifdef SB_OQ_DROP_CNT_EN
    logic [15:0]     drop_count;
`endif

    always #5 clk = ~clk;

    sb_output_queue #(
        .ADDR_BITWIDTH        (AW),
        .DATA_BITWIDTH        (DW),
        .PORT_SEL_BITWIDTH    (PW),
        .QUEUE_DEPTH_BITWIDTH (QW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enq_valid  (enq_valid),
        .enq_port   (enq_port),
        .enq_addr   (enq_addr),
        .enq_ready  (enq_ready),
        .port_ready (port_ready),
        .sb_rd_req  (sb_rd_req),
        .sb_ip      (sb_ip),
        .sb_odata   (sb_odata),
        .out_valid  (out_valid),
        .out_data   (out_data)
`ifdef SB_OQ_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain FIFOs per port plus expected output registers
    logic [AW-1:0] q [NP][$];
    int            rr         = 0;
    int            pend       = -1;
    int            drops      = 0;
    logic          exp_rd_req = 1'b0;
    logic [AW-1:0] exp_ip     = '0;
    logic [NP-1:0] exp_ov     = '0;
    logic [DW-1:0] exp_data   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int            g       = -1;
        logic [AW-1:0] last_ip = exp_ip;
        if (rst) begin
            for (int p = 0; p < NP; p++) q[p].delete();
            rr         = 0;
            pend       = -1;
            drops      = 0;
            exp_rd_req = 1'b0;
            exp_ip     = '0;
            exp_ov     = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                int p;
                p = (rr + i) % NP;
                if (g < 0 && q[p].size() != 0 && port_ready[p]) g = p;
            end
            exp_ov = '0;
            if (pend >= 0) exp_ov[pend] = 1'b1;
            exp_data = ~last_ip;
            pend     = g;
            if (g >= 0) begin
                exp_ip     = q[g].pop_front();
                exp_rd_req = 1'b1;
                rr         = (g + 1) % NP;
            end else begin
                exp_rd_req = 1'b0;
            end
            if (enq_valid) begin
                if (q[enq_port].size() < DEPTH) q[enq_port].push_back(enq_addr);
                else drops++;
            end
        end
    endtask

    task automatic tick();
        #1;
        if (!rst) check("enq_ready", {31'd0, enq_ready}, {31'd0, q[enq_port].size() < DEPTH});
        @(posedge clk);
        model_edge();
        #1;
        sb_odata = (exp_ov != '0) ? exp_data : DW'($urandom);
        #1;
        check("sb_rd_req", {31'd0, sb_rd_req}, {31'd0, exp_rd_req});
        check("sb_ip", 32'(sb_ip), 32'(exp_ip));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov != '0) check("out_data", 32'(out_data), 32'(exp_data));
`ifdef SB_OQ_DROP_CNT_EN
        check("drop_count", 32'(drop_count), (drops > 65535) ? 32'd65535 : 32'(drops));
`endif
    endtask

    task automatic enq(input int port, input int addr);
        enq_valid = 1'b1;
        enq_port  = PW'(port);
        enq_addr  = AW'(addr);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset then idle with all ports ready
        port_ready = 4'hF;
        do_reset();
        for (int i = 0; i < 10; i++) tick();

        // Single word to port 2
        enq(2, 5);
        for (int i = 0; i < 4; i++) tick();

        // Round-robin from a fresh reset
        do_reset();
        port_ready = 4'h0;
        for (int p = 0; p < NP; p++) enq(p, p + 1);
        port_ready = 4'hF;
        for (int i = 0; i < 6; i++) tick();

        // Fill port 0 past its depth, then drain in order
        port_ready = 4'b1110;
        for (int i = 0; i < 9; i++) enq(0, i + 3);
        check("full_enq_ready", {31'd0, enq_ready}, 32'd0);
        port_ready = 4'hF;
        for (int i = 0; i < 11; i++) tick();

        // Not-ready skip
        port_ready = 4'b0000;
        enq(0, 7);
        enq(1, 8);
        enq(1, 9);
        port_ready = 4'b0010;
        for (int i = 0; i < 3; i++) tick();
        port_ready = 4'hF;
        for (int i = 0; i < 3; i++) tick();

        // Reset while a read is in flight
        port_ready = 4'b0000;
        for (int i = 0; i < 3; i++) enq(3, 12 + i);
        port_ready = 4'hF;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Random: congestion phase then draining phase
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 300; i++) begin
                rst       = ($urandom_range(0, 79) == 0);
                enq_valid = (ph == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
                enq_port  = PW'($urandom);
                enq_addr  = AW'($urandom);
                for (int p = 0; p < NP; p++)
                    port_ready[p] = (ph == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
                tick();
            end
        end
        rst       = 1'b0;
        enq_valid = 1'b0;
        port_ready = 4'hF;
        for (int i = 0; i < 40; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
